// File: rtl/alu_writeback.sv
// Execute-to-writeback stage: captures ALU results and commits NZCV flags in order.
// It also drives the register-file write port and forwards the head entry. ALU_WB_SKID_EN selects a 2-entry skid FIFO.
module alu_writeback #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_carry,
    input  logic              in_overflow,
    input  logic              in_arith,
    input  logic              in_set_flags,
    input  logic              in_wr_en,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              flush,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [3:0]        flags_nzcv,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              carry;
        logic              overflow;
        logic              arith;
        logic              set_flags;
        logic              wr_en;
        logic [REG_AW-1:0] rd;
    } entry_t;

    entry_t     in_entry;
    entry_t     head;
    logic [1:0] count_reg, count_next;
    logic [3:0] flags_reg, flags_next;
    logic       has_head;
    logic       retire_now;
    logic       accept;

    assign in_entry = {in_result, in_carry, in_overflow, in_arith, in_set_flags, in_wr_en, in_rd};

    assign has_head   = (count_reg != 2'd0);
    // Compare-only entries never wait for the write port.
    assign retire_now = has_head && !flush && (!head.wr_en || rf_ready);
    assign accept     = in_valid && in_ready;

`ifdef ALU_WB_SKID_EN
    entry_t entry_mem [2];
    logic   head_reg;
    logic   tail_reg;
    logic   ready_reg;

    assign head     = entry_mem[head_reg];
    assign in_ready = ready_reg && !flush;

    always_ff @(posedge clk) begin
        if (accept) begin
            entry_mem[tail_reg] <= in_entry;
        end
    end

    // Ready is precomputed from next occupancy so it never depends on rf_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            ready_reg <= 1'b1;
        end else if (flush) begin
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            if (retire_now) begin
                head_reg <= ~head_reg;
            end
            if (accept) begin
                tail_reg <= ~tail_reg;
            end
            ready_reg <= (count_next != 2'd2);
        end
    end
`else
    entry_t slot_reg;

    assign head     = slot_reg;
    assign in_ready = !flush && (!has_head || retire_now);

    always_ff @(posedge clk) begin
        if (accept) begin
            slot_reg <= in_entry;
        end
    end
`endif

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = 2'd0;
        end else begin
            count_next = count_reg + {1'b0, accept} - {1'b0, retire_now};
        end
    end

    // Logical ops keep the previous V; the adder overflow only matters for arithmetic ops.
    always_comb begin
        flags_next = flags_reg;
        if (retire_now && head.set_flags) begin
            flags_next[3] = head.result[DATA_W-1];
            flags_next[2] = (head.result == '0);
            flags_next[1] = head.carry;
            flags_next[0] = head.arith ? head.overflow : flags_reg[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 2'd0;
            flags_reg <= 4'b0000;
        end else begin
            count_reg <= count_next;
            flags_reg <= flags_next;
        end
    end

    assign rf_we      = has_head && head.wr_en;
    assign rf_waddr   = rf_we ? head.rd : '0;
    assign rf_wdata   = rf_we ? head.result : '0;
    assign fwd_valid  = rf_we;
    assign fwd_rd     = rf_we ? head.rd : '0;
    assign fwd_data   = rf_we ? head.result : '0;
    assign flags_nzcv = flags_reg;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_alu_writeback;
    localparam int DATA_W = 32;
    localparam int REG_AW = 4;
`ifdef ALU_WB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_result = '0;
    logic              in_carry = 1'b0;
    logic              in_overflow = 1'b0;
    logic              in_arith = 1'b0;
    logic              in_set_flags = 1'b0;
    logic              in_wr_en = 1'b0;
    logic [REG_AW-1:0] in_rd = '0;
    logic              flush = 1'b0;
    logic              rf_ready = 1'b0;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [3:0]        flags_nzcv;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [DATA_W-1:0] fwd_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_writeback #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_carry(in_carry), .in_overflow(in_overflow),
        .in_arith(in_arith), .in_set_flags(in_set_flags), .in_wr_en(in_wr_en), .in_rd(in_rd),
        .flush(flush), .rf_ready(rf_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flags_nzcv(flags_nzcv),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    typedef struct {
        logic        v;
        logic [31:0] result;
        logic        carry, ovf, arith, sf, we;
        logic [3:0]  rd;
        logic        rfr, flush;
    } stim_t;

    typedef struct {
        logic [31:0] result;
        logic        carry, ovf, arith, sf, we;
        logic [3:0]  rd;
    } ent_t;

    typedef struct {
        logic        ready, we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  flags;
        logic        fwd;
        logic [3:0]  fwd_rd;
        logic [31:0] fwd_data;
    } obs_t;

    typedef struct {
        stim_t       s;
        logic        ready, we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  flags;
        logic        fwd;
    } vec_t;

    // Reference model: pending results in acceptance order plus committed flags.
    ent_t       q[$];
    logic [3:0] mflags = 4'b0000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic stim_t st(input logic v, input logic [31:0] r, input logic c, input logic ov,
                                 input logic a, input logic sf, input logic we, input logic [3:0] rd,
                                 input logic rfr, input logic fl);
        stim_t s;
        s.v = v; s.result = r; s.carry = c; s.ovf = ov; s.arith = a;
        s.sf = sf; s.we = we; s.rd = rd; s.rfr = rfr; s.flush = fl;
        return s;
    endfunction

    function automatic vec_t mk(input stim_t s, input logic ready, input logic we, input logic [3:0] waddr,
                                input logic [31:0] wdata, input logic [3:0] flags, input logic fwd);
        vec_t x;
        x.s = s; x.ready = ready; x.we = we; x.waddr = waddr;
        x.wdata = wdata; x.flags = flags; x.fwd = fwd;
        return x;
    endfunction

    // Drive one cycle (called just after a falling edge), check against the model, advance it.
    task automatic step(input stim_t s, output obs_t o);
        ent_t h;
        ent_t e;
        bit   has, retiring, exp_ready, exp_we;
        h = '{default: '0};
        in_valid = s.v; in_result = s.result; in_carry = s.carry; in_overflow = s.ovf;
        in_arith = s.arith; in_set_flags = s.sf; in_wr_en = s.we; in_rd = s.rd;
        rf_ready = s.rfr; flush = s.flush;
        #1;
        o.ready = in_ready; o.we = rf_we; o.waddr = rf_waddr; o.wdata = rf_wdata;
        o.flags = flags_nzcv; o.fwd = fwd_valid; o.fwd_rd = fwd_rd; o.fwd_data = fwd_data;
        has = (q.size() > 0);
        if (has) h = q[0];
        exp_we    = has && h.we;
        retiring  = !s.flush && has && (!h.we || s.rfr);
        exp_ready = SKID ? (!s.flush && q.size() < 2) : (!s.flush && (!has || retiring));
        check("model_in_ready", o.ready, exp_ready);
        check("model_rf_we", o.we, exp_we);
        check("model_fwd_valid", o.fwd, exp_we);
        check("model_flags", o.flags, mflags);
        if (exp_we) begin
            check("model_rf_waddr", o.waddr, h.rd);
            check("model_rf_wdata", o.wdata, h.result);
            check("model_fwd_rd", o.fwd_rd, h.rd);
            check("model_fwd_data", o.fwd_data, h.result);
        end
        if (s.flush) begin
            q.delete();
        end else begin
            if (retiring) begin
                void'(q.pop_front());
                if (h.sf) mflags = {h.result[31], h.result == 32'd0, h.carry, h.arith ? h.ovf : mflags[0]};
            end
            if (s.v && exp_ready) begin
                e.result = s.result; e.carry = s.carry; e.ovf = s.ovf; e.arith = s.arith;
                e.sf = s.sf; e.we = s.we; e.rd = s.rd;
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t  vec [10];
    obs_t  o;
    stim_t rs;
    stim_t idle1;
    stim_t idle0;

    initial begin
        idle1 = st(0, 32'h0, 0, 0, 0, 0, 0, 4'd0, 1, 0);
        idle0 = st(0, 32'h0, 0, 0, 0, 0, 0, 4'd0, 0, 0);
        //            stimulus                                                ready we waddr wdata         flags    fwd
        vec[0] = mk(idle1,                                                    1, 0, 4'd0, 32'h0,        4'b0000, 0);
        vec[1] = mk(st(1, 32'h0, 1, 0, 1, 1, 1, 4'd3, 1, 0),                  1, 0, 4'd0, 32'h0,        4'b0000, 0);
        vec[2] = mk(idle1,                                                    1, 1, 4'd3, 32'h0,        4'b0000, 1);
        vec[3] = mk(st(1, 32'h8000_0000, 0, 1, 1, 1, 0, 4'd0, 0, 0),          1, 0, 4'd0, 32'h0,        4'b0110, 0);
        vec[4] = mk(idle0,                                                    1, 0, 4'd0, 32'h0,        4'b0110, 0);
        vec[5] = mk(st(1, 32'h5, 0, 1, 0, 1, 1, 4'd7, 1, 0),                  1, 0, 4'd0, 32'h0,        4'b1001, 0);
        vec[6] = mk(idle1,                                                    1, 1, 4'd7, 32'h5,        4'b1001, 1);
        vec[7] = mk(st(1, 32'h0, 1, 0, 0, 0, 1, 4'd2, 1, 0),                  1, 0, 4'd0, 32'h0,        4'b0001, 0);
        vec[8] = mk(idle1,                                                    1, 1, 4'd2, 32'h0,        4'b0001, 1);
        vec[9] = mk(idle1,                                                    1, 0, 4'd0, 32'h0,        4'b0001, 0);

        // Reset state while rst_n is held low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_rf_we", rf_we, 1'b0);
        check("reset_rf_waddr", rf_waddr, 4'd0);
        check("reset_rf_wdata", rf_wdata, 32'd0);
        check("reset_flags", flags_nzcv, 4'b0000);
        check("reset_fwd_valid", fwd_valid, 1'b0);
        check("reset_fwd_rd", fwd_rd, 4'd0);
        check("reset_fwd_data", fwd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(vec[i].s, o);
            check($sformatf("vec%0d_in_ready", i), o.ready, vec[i].ready);
            check($sformatf("vec%0d_rf_we", i), o.we, vec[i].we);
            check($sformatf("vec%0d_flags", i), o.flags, vec[i].flags);
            check($sformatf("vec%0d_fwd_valid", i), o.fwd, vec[i].fwd);
            if (vec[i].we) begin
                check($sformatf("vec%0d_rf_waddr", i), o.waddr, vec[i].waddr);
                check($sformatf("vec%0d_rf_wdata", i), o.wdata, vec[i].wdata);
            end
            $display("vec %0d: v=%0b rd=%0d result=%h -> rf_we=%0b waddr=%0d wdata=%h flags=%b",
                     i, vec[i].s.v, vec[i].s.rd, vec[i].s.result, o.we, o.waddr, o.wdata, o.flags);
        end

        // Back-to-back writes to rd=1 and rd=2 while the write port stalls for three cycles.
        step(st(1, 32'h11, 0, 0, 0, 0, 1, 4'd1, 0, 0), o);
        check("b2b_a0_in_ready", o.ready, 1'b1);
        step(st(1, 32'h22, 0, 0, 0, 0, 1, 4'd2, 0, 0), o);
        check("b2b_a1_in_ready", o.ready, SKID);
        check("b2b_a1_rf_we", o.we, 1'b1);
        check("b2b_a1_rf_waddr", o.waddr, 4'd1);
        check("b2b_a1_rf_wdata", o.wdata, 32'h11);
        step(st(!SKID, 32'h22, 0, 0, 0, 0, 1, 4'd2, 0, 0), o);
        check("b2b_a2_in_ready", o.ready, 1'b0);
        check("b2b_a2_rf_waddr", o.waddr, 4'd1);
        check("b2b_a2_rf_wdata", o.wdata, 32'h11);
        step(st(!SKID, 32'h22, 0, 0, 0, 0, 1, 4'd2, 1, 0), o);
        check("b2b_a3_in_ready", o.ready, !SKID);
        check("b2b_a3_rf_we", o.we, 1'b1);
        check("b2b_a3_rf_waddr", o.waddr, 4'd1);
        check("b2b_a3_rf_wdata", o.wdata, 32'h11);
        step(idle1, o);
        check("b2b_a4_rf_we", o.we, 1'b1);
        check("b2b_a4_rf_waddr", o.waddr, 4'd2);
        check("b2b_a4_rf_wdata", o.wdata, 32'h22);
        step(idle1, o);
        check("b2b_a5_rf_we", o.we, 1'b0);
        $display("seq back_to_back: done, flags=%b", o.flags);

        // Flush a pending flag-setting write; the in_valid offered during flush must be dropped.
        step(st(1, 32'hFFFF_0000, 1, 1, 1, 1, 1, 4'd5, 0, 0), o);
        step(idle0, o);
        check("flush_pre_rf_we", o.we, 1'b1);
        check("flush_pre_fwd_valid", o.fwd, 1'b1);
        check("flush_pre_fwd_rd", o.fwd_rd, 4'd5);
        step(st(1, 32'h0, 1, 0, 1, 1, 1, 4'd6, 1, 1), o);
        check("flush_in_ready", o.ready, 1'b0);
        step(idle1, o);
        check("flush_post_rf_we", o.we, 1'b0);
        check("flush_post_fwd_valid", o.fwd, 1'b0);
        check("flush_post_flags", o.flags, 4'b0001);
        check("flush_post_in_ready", o.ready, 1'b1);
        step(idle1, o);
        check("flush_post2_flags", o.flags, 4'b0001);
        $display("seq flush: done, flags=%b", o.flags);

        // Asynchronous reset between clock edges with an entry pending.
        step(st(1, 32'h1234_5678, 1, 0, 1, 1, 1, 4'd9, 0, 0), o);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_rf_we", rf_we, 1'b0);
        check("areset_rf_waddr", rf_waddr, 4'd0);
        check("areset_rf_wdata", rf_wdata, 32'd0);
        check("areset_flags", flags_nzcv, 4'b0000);
        check("areset_fwd_valid", fwd_valid, 1'b0);
        check("areset_fwd_rd", fwd_rd, 4'd0);
        check("areset_fwd_data", fwd_data, 32'd0);
        q.delete();
        mflags = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(idle1, o);
        check("areset_post_in_ready", o.ready, 1'b1);
        $display("seq async_reset: done");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            rs.v = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 3))
                0:       rs.result = 32'h0;
                1:       rs.result = 32'h8000_0000;
                default: rs.result = $urandom;
            endcase
            rs.carry = 1'($urandom_range(0, 1));
            rs.ovf   = 1'($urandom_range(0, 1));
            rs.arith = 1'($urandom_range(0, 1));
            rs.sf    = 1'($urandom_range(0, 1));
            rs.we    = ($urandom_range(0, 3) != 0);
            rs.rd    = 4'($urandom_range(0, 15));
            rs.rfr   = 1'($urandom_range(0, 1));
            rs.flush = ($urandom_range(0, 19) == 0);
            step(rs, o);
        end
        $display("seq random: 400 cycles, flags=%b", flags_nzcv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Execute-to-writeback pipeline stage directly downstream of the ALU.
- Captures each ALU result with its destination and flag-update controls, commits NZCV flags in program order, and drives the register-file write port under a valid/ready handshake.
- Exposes the head entry as a forwarding source for the operand stage upstream of the ALU.

Parameters:
- DATA_W, 32, result / write-data width.
- REG_AW, 4, register-file address width (16 registers).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  stage can accept.
- in_result  in  DATA_W  ALU result.
- in_carry  in  1  carry out (adder carry for arithmetic ops, shifter carry for logical ops).
- in_overflow  in  1  signed overflow from the adder.
- in_arith  in  1  1 = arithmetic op (ADD/SUB/compare), 0 = logical/move/multiply.
- in_set_flags  in  1  S bit: update NZCV on commit.
- in_wr_en  in  1  write result to register file (0 for compare-only ops).
- in_rd  in  REG_AW  destination register.
- flush  in  1  synchronous kill of all pending entries.
- rf_ready  in  1  register-file write port available.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  DATA_W  write data.
- flags_nzcv  out  4  committed flags {N,Z,C,V}.
- fwd_valid  out  1  head entry pending with in_wr_en=1.
- fwd_rd  out  REG_AW  head destination.
- fwd_data  out  DATA_W  head result.

Behaviour:
- Reset (async, rst_n=0): all entries invalid. in_ready=1 once rst_n deasserts. rf_we=0, rf_waddr=0, rf_wdata=0, flags_nzcv=4'b0000, fwd_valid=0, fwd_rd=0, fwd_data=0. Reset mid-operation discards pending entries; flags are not committed.
- Accept: entry captured at the edge where in_valid & in_ready. Its outputs appear the following cycle (1-cycle latency).
- Head entry with wr_en=1:
  - rf_we=1, rf_waddr=rd, rf_wdata=result.
  - Retires at the edge where rf_we & rf_ready.
  - rf_we, rf_waddr and rf_wdata hold stable while rf_ready=0.
- Head entry with wr_en=0: rf_we=0; retires on the next edge regardless of rf_ready.
- Flag commit: on the retire edge, if set_flags=1:
  - N=result[DATA_W-1].
  - Z=(result==0).
  - C=carry.
  - V=overflow if arith=1, else V is preserved.
  - If set_flags=0, flags_nzcv is unchanged.
- Flags commit strictly in acceptance order. Flags are never updated by a flushed entry.
- in_ready (baseline): =!full | retire_now. This is a combinational path from rf_ready. Simultaneous retire and accept in the same cycle is legal and loses no entry.
- flush: on the flush edge, all entries are invalidated, nothing retires, flags are unchanged, and in_valid is ignored. in_ready=0 during the flush cycle.
- Forwarding: fwd_* mirror the head entry. fwd_valid=0 when empty or when head wr_en=0.
- No state machine beyond the entry valid bits / occupancy count. Occupancy never exceeds capacity; an accept while full is impossible by construction.

Optional Feature:
- Macro: ALU_WB_SKID_EN.
- Defined:
  - Two-entry in-order FIFO (head/tail pointers wrap modulo 2, 2-bit count).
  - in_ready=(count<2) is registered, with no combinational dependence on rf_ready.
  - Full throughput is sustained when rf_ready toggles.
  - Flush clears both entries.
  - fwd_* reflect the head only.
- Undefined: single entry; in_ready as described in Behaviour.

Test Plan:
- Reset release, then accept ADD with result=0x00000000, carry=1, overflow=0, arith=1, set_flags=1, wr_en=1, rd=3, rf_ready=1.
  - Next cycle: rf_we=1, rf_waddr=3, rf_wdata=0.
  - Following cycle: flags_nzcv=4'b0110.
- CMP with result=0x80000000, wr_en=0, set_flags=1, arith=1, overflow=1, rf_ready=0 held.
  - Retires one cycle after acceptance; flags_nzcv=4'b1001; rf_we stays 0.
- Logical op with result=0x5, carry=0, arith=0, set_flags=1, after V=1 was committed.
  - flags_nzcv=4'b0001 (V preserved).
- Back-to-back results rd=1, rd=2 with rf_ready low for 3 cycles.
  - rf_wdata and rf_waddr hold stable for rd=1; in_ready=0 while full (baseline).
  - Both writes occur in order after rf_ready=1.
  - With ALU_WB_SKID_EN: second entry is accepted; in_ready=0 only after both are held.
- Pending rd=5 entry with set_flags=1 and rf_ready=0, then assert flush.
  - Next cycle: rf_we=0, fwd_valid=0, flags_nzcv unchanged, in_ready=1.
- Assert rst_n=0 asynchronously between clock edges with an entry pending.
  - All outputs go to their reset values immediately, without waiting for a clock edge.
